// File: rtl/pixel_framebuffer.sv
// 1-bit-per-pixel framebuffer with a clear sweep that runs after reset and on request,
// a single write port with range checking and a latency-1, read-first scan-out port.
module pixel_framebuffer #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_valid,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        pixel_color,
    output logic        wr_ready,
    input  logic        clear,
    output logic        busy,
    output logic        clear_done,
    input  logic [10:0] rd_x,
    input  logic [10:0] rd_y,
    output logic        rd_pixel,
    output logic [15:0] drop_count,
    output logic        state_dbg
);

    localparam int DEPTH = H_PIXELS * V_PIXELS;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [31:0] H_LIM = 32'(H_PIXELS);
    localparam logic [31:0] V_LIM = 32'(V_PIXELS);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Write handshake: a write transfers on any cycle where wr_valid && wr_ready;
    // wr_ready is combinational and never depends on wr_valid.
    state_t          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic [15:0]     drop_q, drop_d;
    logic            rd_pixel_q;
    logic            mem_q [DEPTH];

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic            mem_wdata;

    logic            wr_in_range;
    logic [AW-1:0]   wr_addr;
    logic            rd_in_range;
    logic [AW-1:0]   rd_addr;

    assign wr_in_range = (32'(x) < H_LIM) && (32'(y) < V_LIM);
    assign wr_addr     = AW'(y) * AW'(H_PIXELS) + AW'(x);
    assign rd_in_range = (32'(rd_x) < H_LIM) && (32'(rd_y) < V_LIM);
    assign rd_addr     = AW'(rd_y) * AW'(H_PIXELS) + AW'(rd_x);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        mem_waddr  = clr_addr_q;
        mem_wdata  = 1'b0;
        busy       = 1'b0;
        clear_done = 1'b0;
        wr_ready   = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                // clear requests are ignored here: the sweep never restarts
                busy   = 1'b1;
                mem_we = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    clear_done = 1'b1;
                    clr_addr_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                wr_ready = !clear;
                if (clear) begin
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end else if (wr_valid) begin
                    if (wr_in_range) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr;
                        mem_wdata = pixel_color;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_d = drop_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            drop_q     <= '0;
            rd_pixel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            drop_q     <= drop_d;
            rd_pixel_q <= rd_in_range ? mem_q[rd_addr] : 1'b0;
        end
    end

    // Storage is deliberately not reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_pixel   = rd_pixel_q;
    assign drop_count = drop_q;
    assign state_dbg  = (state_q == ST_CLEAR);

endmodule

// File: doc/pixel_framebuffer.md
PIXEL_FRAMEBUFFER -- requirements
Module: pixel_framebuffer

Interface
REQ-001 Parameter H_PIXELS, default 640: horizontal resolution in pixels.
REQ-002 Parameter V_PIXELS, default 480: vertical resolution in pixels.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_valid  input  1  pixel write request from the line-drawing side.
REQ-006 x  input  11  write column.
REQ-007 y  input  11  write row.
REQ-008 pixel_color  input  1  write data: 0 = black, 1 = white.
REQ-009 wr_ready  output  1  write accepted this cycle when wr_valid && wr_ready.
REQ-010 clear  input  1  single-cycle request to blank the whole buffer.
REQ-011 busy  output  1  high while a clear sweep is in progress.
REQ-012 clear_done  output  1  one-cycle pulse on the final clear write.
REQ-013 rd_x  input  11  scan-out read column.
REQ-014 rd_y  input  11  scan-out read row.
REQ-015 rd_pixel  output  1  stored pixel for the (rd_x, rd_y) presented one cycle earlier.
REQ-016 drop_count  output  16  number of out-of-range writes, saturating.

Function
REQ-017 Storage SHALL be H_PIXELS*V_PIXELS 1-bit cells, address = y*H_PIXELS + x, address width ceil(log2(H_PIXELS*V_PIXELS)).
REQ-018 The FSM SHALL have states CLEAR and IDLE.
REQ-019 In CLEAR, one cell per cycle SHALL be written 0, ascending from address 0; the transition to IDLE SHALL occur after the write to the last address.
REQ-020 clear_done SHALL pulse high for exactly the cycle that writes the last address; busy SHALL be high for every cycle in CLEAR.
REQ-021 In IDLE, clear=1 SHALL enter CLEAR starting at address 0 the next cycle; clear while in CLEAR SHALL be ignored, with no restart.
REQ-022 wr_ready SHALL equal (state == IDLE) && !clear, combinationally.
REQ-023 A write SHALL be accepted only on wr_valid && wr_ready; an in-range write (x < H_PIXELS, y < V_PIXELS) SHALL store pixel_color at the end of that cycle.
REQ-024 An accepted out-of-range write SHALL not modify storage and SHALL increment drop_count by 1, saturating at 16'hFFFF.
REQ-025 Same-cycle clear and wr_valid in IDLE: clear SHALL win, and the write SHALL be neither accepted nor counted.
REQ-026 The read port SHALL operate in every state with latency 1: rd_pixel at cycle N+1 reflects (rd_x, rd_y) sampled at posedge N.
REQ-027 An out-of-range read address SHALL yield rd_pixel = 0.
REQ-028 A read and a write (or clear write) to the same address in one cycle SHALL return the old data (read-first).
REQ-029 During CLEAR, reads SHALL return the current cell contents: cleared cells read 0, not-yet-cleared cells read their prior value.

Reset
REQ-030 On reset asserted (low), the block SHALL immediately enter CLEAR with clear address 0; drop_count = 0, rd_pixel = 0, clear_done = 0, busy = 1, wr_ready = 0.
REQ-031 After reset deasserts, the block SHALL perform a full clear sweep before accepting writes, so memory is defined without an init file.
REQ-032 A reset asserted mid-sweep or mid-write SHALL abort the operation and restart the sweep at address 0.

Verification (H_PIXELS=8, V_PIXELS=4)
REQ-033 Release reset, hold clear=0 -> busy=1 for 32 cycles, clear_done pulses on the 32nd, then wr_ready=1 and every read returns 0.
REQ-034 Write (3,2,1) with wr_valid=1 in IDLE; on the next cycle set rd=(3,2) -> rd_pixel=1 one cycle later; rd=(2,3) -> 0.
REQ-035 Write (8,0,1), then (0,4,1), then 65537 further out-of-range writes -> drop_count = 2, then saturates at 16'hFFFF; storage unchanged.
REQ-036 Assert clear and wr_valid(1,1,1) in the same cycle -> wr_ready=0, write not stored, sweep runs 32 cycles, cell (1,1) reads 0.
REQ-037 Set cell (5,1)=1; clear; during the sweep read (5,1) -> 1 until address 13 is cleared, 0 afterwards; a clear pulse mid-sweep does not extend busy.
REQ-038 Assert reset at sweep address 10 -> wr_ready=0 immediately; after release, the sweep restarts at 0 and lasts 32 cycles.
